// File: rtl/lc3_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : lc3_operand_fetch
// Purpose  : LC-3 register-read / issue stage. Decodes the source and
//            destination fields of a fetched instruction, drives the register
//            file read selects, bypasses same-cycle writeback data, stalls on
//            RAW/WAW hazards tracked by a per-register pending scoreboard and
//            registers the operands into one valid/ready output stage.
// Ports    :
//   clk_i          clock, all state on rising edge
//   rst_ni         synchronous active-low reset
//   in_valid_i     IR/PC valid from fetch
//   in_ready_o     stage can accept IR/PC this cycle
//   ir_i, pc_i     instruction word and (incremented) PC
//   sr1_o, sr2_o   register file read selects (combinational from ir_i)
//   sr1out_i,
//   sr2out_i       register file read data
//   wb_en_i,
//   wb_dr_i,
//   wb_data_i      writeback strobe / destination / data
//   out_valid_o    issued instruction valid
//   out_ready_i    execute accepts
//   out_opcode_o   ir[15:12] of the issued instruction
//   out_a_o,
//   out_b_o        operands A and B
//   out_dr_o       destination register
//   out_wen_o      issued instruction writes out_dr_o
//   out_pc_o       registered pc
// Revision : 1.0 - initial release
// ============================================================================
module lc3_operand_fetch #(
    parameter int WIDTH   = 16,
    parameter bit FORWARD = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] ir_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic [2:0]       sr1_o,
    output logic [2:0]       sr2_o,
    input  logic [WIDTH-1:0] sr1out_i,
    input  logic [WIDTH-1:0] sr2out_i,
    input  logic             wb_en_i,
    input  logic [2:0]       wb_dr_i,
    input  logic [WIDTH-1:0] wb_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       out_opcode_o,
    output logic [WIDTH-1:0] out_a_o,
    output logic [WIDTH-1:0] out_b_o,
    output logic [2:0]       out_dr_o,
    output logic             out_wen_o,
    output logic [WIDTH-1:0] out_pc_o
);

    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_NOT = 4'b1001;
    localparam logic [3:0] c_OP_LD  = 4'b0010;
    localparam logic [3:0] c_OP_LDR = 4'b0110;
    localparam logic [3:0] c_OP_LDI = 4'b1010;
    localparam logic [3:0] c_OP_LEA = 4'b1110;
    localparam logic [3:0] c_OP_ST  = 4'b0011;
    localparam logic [3:0] c_OP_STI = 4'b1011;
    localparam logic [3:0] c_OP_STR = 4'b0111;
    localparam logic [3:0] c_OP_JMP = 4'b1100;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0]       w_op;
    logic [2:0]       w_dr;
    logic             w_is_store;
    logic             w_is_alu;
    logic             w_imm_mode;
    logic             w_use_a;
    logic             w_use_b;
    logic             w_writes;
    logic [WIDTH-1:0] w_imm;

    assign w_op       = ir_i[15:12];
    assign w_dr       = ir_i[11:9];
    assign w_is_store = (w_op == c_OP_ST) || (w_op == c_OP_STI) || (w_op == c_OP_STR);
    assign w_is_alu   = (w_op == c_OP_ADD) || (w_op == c_OP_AND);
    assign w_imm_mode = w_is_alu && ir_i[5];
    assign w_use_a    = w_is_alu || (w_op == c_OP_NOT) || (w_op == c_OP_LDR) ||
                        (w_op == c_OP_STR) || (w_op == c_OP_JMP);
    assign w_use_b    = (w_is_alu && !ir_i[5]) || w_is_store;
    assign w_writes   = w_is_alu || (w_op == c_OP_NOT) || (w_op == c_OP_LD) ||
                        (w_op == c_OP_LDR) || (w_op == c_OP_LDI) || (w_op == c_OP_LEA);
    assign w_imm      = {{(WIDTH-5){ir_i[4]}}, ir_i[4:0]};

    // Stores read the data register through port B so port A stays free
    // for the base register.
    assign sr1_o = ir_i[8:6];
    assign sr2_o = w_is_store ? ir_i[11:9] : ir_i[2:0];

    // ------------------------------------------------------------------
    // Writeback bypass and hazard detection
    // ------------------------------------------------------------------
    logic [7:0]       pending_q;
    logic [7:0]       pending_d;
    logic             w_clr_s1;
    logic             w_clr_s2;
    logic             w_clr_dr;
    logic             w_blk_a;
    logic             w_blk_b;
    logic             w_hazard;
    logic             w_issue;
    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;

    assign w_clr_s1 = wb_en_i && (wb_dr_i == sr1_o);
    assign w_clr_s2 = wb_en_i && (wb_dr_i == sr2_o);
    assign w_clr_dr = wb_en_i && (wb_dr_i == w_dr);

    // With bypass, a pending source being written this cycle is safe to
    // take from the bus. Without bypass, any source being written this
    // cycle must wait until the register file holds the new value.
    assign w_blk_a = FORWARD ? (pending_q[sr1_o] && !w_clr_s1)
                             : (pending_q[sr1_o] || w_clr_s1);
    assign w_blk_b = FORWARD ? (pending_q[sr2_o] && !w_clr_s2)
                             : (pending_q[sr2_o] || w_clr_s2);

    assign w_hazard = (w_use_a && w_blk_a) || (w_use_b && w_blk_b) ||
                      (w_writes && pending_q[w_dr] && !w_clr_dr);

    assign w_src_a = (FORWARD && w_clr_s1) ? wb_data_i : sr1out_i;
    assign w_src_b = w_imm_mode            ? w_imm     :
                     (FORWARD && w_clr_s2) ? wb_data_i : sr2out_i;

    // Held low during reset so nothing is taken from fetch while the
    // stage is being cleared.
    assign in_ready_o = rst_ni && (!out_valid_o || out_ready_i) && !w_hazard;
    assign w_issue    = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // Scoreboard: a set on issue overrides a clear from writeback.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (wb_en_i) begin
            pending_d[wb_dr_i] = 1'b0;
        end
        if (w_issue && w_writes) begin
            pending_d[w_dr] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= 8'h00;
        end else begin
            pending_q <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic             out_valid_q;
    logic [3:0]       out_opcode_q;
    logic [WIDTH-1:0] out_a_q;
    logic [WIDTH-1:0] out_b_q;
    logic [2:0]       out_dr_q;
    logic             out_wen_q;
    logic [WIDTH-1:0] out_pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_opcode_q <= 4'h0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_dr_q     <= 3'd0;
            out_wen_q    <= 1'b0;
            out_pc_q     <= '0;
        end else if (w_issue) begin
            out_valid_q  <= 1'b1;
            out_opcode_q <= w_op;
            out_a_q      <= w_src_a;
            out_b_q      <= w_src_b;
            out_dr_q     <= w_dr;
            out_wen_q    <= w_writes;
            out_pc_q     <= pc_i;
        end else if (out_ready_i) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_opcode_o = out_opcode_q;
    assign out_a_o      = out_a_q;
    assign out_b_o      = out_b_q;
    assign out_dr_o     = out_dr_q;
    assign out_wen_o    = out_wen_q;
    assign out_pc_o     = out_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_operand_fetch
// Purpose  : Bench for lc3_operand_fetch. Two instances (bypass on / off)
//            share one stimulus stream and one register file model. A
//            reference model predicts in_ready, sources, scoreboard state and
//            issued operands; issued results are queued and a monitor compares
//            them against whatever each instance presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_operand_fetch;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dr;
        logic        wen;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        out_ready;
    logic        wb_en;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;

    logic [15:0] regs [8];

    logic        in_ready   [2];
    logic [2:0]  sr1        [2];
    logic [2:0]  sr2        [2];
    logic [15:0] sr1out     [2];
    logic [15:0] sr2out     [2];
    logic        out_valid  [2];
    logic [3:0]  out_opcode [2];
    logic [15:0] out_a      [2];
    logic [15:0] out_b      [2];
    logic [2:0]  out_dr     [2];
    logic        out_wen    [2];
    logic [15:0] out_pc     [2];

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] pend_m [2];
    logic       ov_m   [2];

    always #5 clk = ~clk;

    assign sr1out[0] = regs[sr1[0]];
    assign sr2out[0] = regs[sr2[0]];
    assign sr1out[1] = regs[sr1[1]];
    assign sr2out[1] = regs[sr2[1]];

    lc3_operand_fetch #(.WIDTH(16), .FORWARD(1'b1)) u_fwd (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .ir_i(ir), .pc_i(pc),
        .sr1_o(sr1[0]), .sr2_o(sr2[0]),
        .sr1out_i(sr1out[0]), .sr2out_i(sr2out[0]),
        .wb_en_i(wb_en), .wb_dr_i(wb_dr), .wb_data_i(wb_data),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
        .out_opcode_o(out_opcode[0]), .out_a_o(out_a[0]), .out_b_o(out_b[0]),
        .out_dr_o(out_dr[0]), .out_wen_o(out_wen[0]), .out_pc_o(out_pc[0])
    );

    lc3_operand_fetch #(.WIDTH(16), .FORWARD(1'b0)) u_nof (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .ir_i(ir), .pc_i(pc),
        .sr1_o(sr1[1]), .sr2_o(sr2[1]),
        .sr1out_i(sr1out[1]), .sr2out_i(sr2out[1]),
        .wb_en_i(wb_en), .wb_dr_i(wb_dr), .wb_data_i(wb_data),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
        .out_opcode_o(out_opcode[1]), .out_a_o(out_a[1]), .out_b_o(out_b[1]),
        .out_dr_o(out_dr[1]), .out_wen_o(out_wen[1]), .out_pc_o(out_pc[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: whatever an instance presents must equal the oldest
    // predicted issue; it is retired on the handshake.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t act0, act1;
        act0 = '{op: out_opcode[0], a: out_a[0], b: out_b[0], dr: out_dr[0],
                 wen: out_wen[0], pc: out_pc[0]};
        act1 = '{op: out_opcode[1], a: out_a[1], b: out_b[1], dr: out_dr[1],
                 wen: out_wen[1], pc: out_pc[1]};
        if (out_valid[0] === 1'b1) begin
            if (q0.size() == 0) chk("fwd_unexpected_out", 64'(act0), 64'hDEAD);
            else begin
                chk("fwd_out", 64'(act0), 64'(q0[0]));
                if (out_ready) void'(q0.pop_front());
            end
        end
        if (out_valid[1] === 1'b1) begin
            if (q1.size() == 0) chk("nof_unexpected_out", 64'(act1), 64'hDEAD);
            else begin
                chk("nof_out", 64'(act1), 64'(q1[0]));
                if (out_ready) void'(q1.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: one clock of both instances, driven from the
    // instruction-set rules.
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            bit          fwd;
            logic [3:0]  op;
            bit          st, alu, ua, ub, wr, imm, stall, ready, acc;
            logic [2:0]  s1, s2, d;
            logic [15:0] va, vb;
            exp_t        e;
            fwd = (k == 0);
            op  = ir[15:12];
            st  = op inside {4'd3, 4'd11, 4'd7};
            alu = op inside {4'd1, 4'd5};
            s1  = ir[8:6];
            s2  = st ? ir[11:9] : ir[2:0];
            d   = ir[11:9];
            ua  = alu || (op inside {4'd9, 4'd6, 4'd7, 4'd12});
            imm = alu && ir[5];
            ub  = (alu && !ir[5]) || st;
            wr  = alu || (op inside {4'd9, 4'd2, 4'd6, 4'd10, 4'd14});
            stall = 1'b0;
            if (ua && (fwd ? (pend_m[k][s1] && !(wb_en && wb_dr == s1))
                           : (pend_m[k][s1] || (wb_en && wb_dr == s1)))) stall = 1'b1;
            if (ub && (fwd ? (pend_m[k][s2] && !(wb_en && wb_dr == s2))
                           : (pend_m[k][s2] || (wb_en && wb_dr == s2)))) stall = 1'b1;
            if (wr && pend_m[k][d] && !(wb_en && wb_dr == d)) stall = 1'b1;
            ready = rst_n && (!ov_m[k] || out_ready) && !stall;
            acc   = ready && in_valid;

            va = (fwd && wb_en && wb_dr == s1) ? wb_data : regs[s1];
            if (imm) vb = {{11{ir[4]}}, ir[4:0]};
            else     vb = (fwd && wb_en && wb_dr == s2) ? wb_data : regs[s2];

            chk(k == 0 ? "fwd_in_ready" : "nof_in_ready", 64'(in_ready[k]), 64'(ready));
            chk(k == 0 ? "fwd_out_valid" : "nof_out_valid", 64'(out_valid[k]), 64'(ov_m[k]));
            chk(k == 0 ? "fwd_sel" : "nof_sel", 64'({sr1[k], sr2[k]}), 64'({s1, s2}));
            chk(k == 0 ? "fwd_pending" : "nof_pending",
                64'(k == 0 ? u_fwd.pending_q : u_nof.pending_q), 64'(pend_m[k]));

            if (!rst_n) begin
                pend_m[k] = 8'h00;
                ov_m[k]   = 1'b0;
                if (k == 0) q0.delete(); else q1.delete();
            end else begin
                if (acc) begin
                    e = '{op: op, a: va, b: vb, dr: d, wen: wr, pc: pc};
                    if (k == 0) q0.push_back(e); else q1.push_back(e);
                end
                if (wb_en) pend_m[k][wb_dr] = 1'b0;
                if (acc && wr) pend_m[k][d] = 1'b1;
                ov_m[k] = acc ? 1'b1 : (out_ready ? 1'b0 : ov_m[k]);
            end
        end
        @(posedge clk);
        #1;
        if (wb_en) regs[wb_dr] = wb_data;
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] i,
                         input logic ordy, input logic we, input logic [2:0] wd,
                         input logic [15:0] wdat);
        rst_n = r; in_valid = v; ir = i; out_ready = ordy;
        wb_en = we; wb_dr = wd; wb_data = wdat;
        pc = pc + 16'd1;
    endtask

    initial begin
        for (int r = 0; r < 8; r++) regs[r] = 16'(r * 16'h0111);
        regs[2] = 16'h0005;
        regs[4] = 16'h1234;
        regs[5] = 16'h3000;
        pend_m[0] = 8'h00; pend_m[1] = 8'h00;
        ov_m[0]   = 1'b0;  ov_m[1]   = 1'b0;
        pc = 16'h3000;
        drive(1'b0, 1'b1, 16'h12BD, 1'b1, 1'b0, 3'd0, 16'h0000);

        // Reset with a valid instruction waiting
        step();
        chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst_outputs", 64'({out_opcode[1], out_a[1], out_b[1], out_dr[1], out_wen[1], out_pc[1]}), 64'd0);
        step();

        // ADD R1,R2,#-3
        drive(1'b1, 1'b1, 16'h12BD, 1'b1, 1'b0, 3'd0, 16'h0000);
        step();
        chk("add_imm_a", 64'(out_a[0]), 64'h0005);
        chk("add_imm_b", 64'(out_b[0]), 64'hFFFD);
        chk("add_imm_dr_wen", 64'({out_dr[1], out_wen[1]}), 64'({3'd1, 1'b1}));

        // ADD R3,R1,R2 stalls on pending R1
        drive(1'b1, 1'b1, 16'h1642, 1'b1, 1'b0, 3'd0, 16'h0000);
        step(); step(); step();
        drive(1'b1, 1'b1, 16'h1642, 1'b1, 1'b1, 3'd1, 16'h0042);
        step();
        chk("fwd_bypass_a", 64'(out_a[0]), 64'h0042);
        drive(1'b1, 1'b1, 16'h1642, 1'b1, 1'b0, 3'd0, 16'h0000);
        step();
        chk("nof_late_a", 64'(out_a[1]), 64'h0042);

        // STR R4,R5,#1 under back-pressure, then release
        drive(1'b1, 1'b1, 16'h7941, 1'b0, 1'b0, 3'd0, 16'h0000);
        #1;
        chk("str_sel", 64'({sr1[0], sr2[0]}), 64'({3'd5, 3'd4}));
        step(); step(); step(); step();
        drive(1'b1, 1'b1, 16'h7941, 1'b1, 1'b0, 3'd0, 16'h0000);
        step();
        chk("str_ops", 64'({out_a[1], out_b[1], out_wen[1]}), 64'({16'h3000, 16'h1234, 1'b0}));

        // LD R6 twice: WAW stall, released by a same-cycle writeback to R6
        drive(1'b1, 1'b1, 16'h2C00, 1'b1, 1'b0, 3'd0, 16'h0000);
        step();
        step();
        drive(1'b1, 1'b1, 16'h2C00, 1'b1, 1'b1, 3'd6, 16'h0666);
        step();
        chk("waw_set_wins", 64'(u_fwd.pending_q[6]), 64'd1);
        drive(1'b1, 1'b1, 16'h2C00, 1'b0, 1'b0, 3'd0, 16'h0000);
        step();

        // Reset while stalled and holding an output
        drive(1'b0, 1'b1, 16'h2C00, 1'b0, 1'b0, 3'd0, 16'h0000);
        step();
        chk("rst_mid_valid", 64'({out_valid[0], out_valid[1]}), 64'd0);
        chk("rst_mid_pending", 64'({u_fwd.pending_q, u_nof.pending_q}), 64'd0);
        drive(1'b1, 1'b1, 16'h2C00, 1'b1, 1'b0, 3'd0, 16'h0000);
        step();
        chk("after_rst_issue", 64'({out_valid[0], out_valid[1]}), 64'({1'b1, 1'b1}));

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom));
            step();
        end

        // Drain
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000);
            step();
        end
        chk("drain_fwd", 64'(q0.size()), 64'd0);
        chk("drain_nof", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
